// File: rtl/image_gen_pkg.sv
// Shared types and default screen geometry for the checkerboard frame painter.
package image_gen_pkg;

  typedef enum logic {
    PAINT = 1'b0,
    GAP   = 1'b1
  } state_t;

  localparam int SCREEN_BASE          = 16384;
  localparam int SCREEN_WORDS_PER_ROW = 32;
  localparam int SCREEN_ROWS          = 256;
  localparam int SCREEN_TILE_SHIFT    = 4;
  localparam int SCREEN_GAP_CYCLES    = 4;

endpackage

// File: rtl/image_pattern.sv
// Combinational pixel word for a given screen row/word column and frame parity:
// tiled checkerboard plus a one-pixel border around the whole screen.
module image_pattern
  import image_gen_pkg::*;
#(
  parameter int ROWS          = SCREEN_ROWS,
  parameter int WORDS_PER_ROW = SCREEN_WORDS_PER_ROW,
  parameter int TILE_SHIFT    = SCREEN_TILE_SHIFT,
  parameter int RW            = $clog2(ROWS),
  parameter int CW            = $clog2(WORDS_PER_ROW)
) (
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  input  logic          i_frame_odd,
  output logic [15:0]   o_word
);

  logic w_tile;
  logic w_top_bottom;

  // Only the low bit of (row >> TILE_SHIFT) ^ col ^ frame decides the tile colour.
  assign w_tile       = i_row[TILE_SHIFT] ^ i_col[0] ^ i_frame_odd;
  assign w_top_bottom = (i_row == '0) || (i_row == RW'(ROWS - 1));

  always_comb begin
    o_word = w_tile ? 16'hFFFF : 16'h0000;
    if (w_top_bottom) begin
      o_word = 16'hFFFF;
    end else begin
      if (i_col == '0)                        o_word = o_word | 16'h0001;
      if (i_col == CW'(WORDS_PER_ROW - 1))    o_word = o_word | 16'h8000;
    end
  end

endmodule

// File: rtl/image_generator.sv
// Self-running painter: writes one screen word per clock, then idles for a short
// gap, flipping the checkerboard phase on every frame.
module image_generator
  import image_gen_pkg::*;
#(
  parameter int BASE_ADDR     = SCREEN_BASE,
  parameter int WORDS_PER_ROW = SCREEN_WORDS_PER_ROW,
  parameter int ROWS          = SCREEN_ROWS,
  parameter int TILE_SHIFT    = SCREEN_TILE_SHIFT,
  parameter int GAP_CYCLES    = SCREEN_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] address,
  output logic        load,
  output logic [15:0] out,
  output state_t      o_dbg_state
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(WORDS_PER_ROW);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // r_row/r_col name the word the next PAINT edge will present; r_state is the
  // kind of cycle the next edge produces.
  state_t        r_state, w_state_n;
  logic [RW-1:0] r_row, w_row_n;
  logic [CW-1:0] r_col, w_col_n;
  logic [7:0]    r_frame, w_frame_n;
  logic [GW-1:0] r_gap, w_gap_n;
  logic [15:0]   r_address, w_address_n;
  logic          r_load, w_load_n;
  logic [15:0]   r_out, w_out_n;

  logic [15:0]   w_pattern;
  logic [15:0]   w_word_addr;
  logic          w_last_col;
  logic          w_last_row;

  image_pattern #(
    .ROWS         (ROWS),
    .WORDS_PER_ROW(WORDS_PER_ROW),
    .TILE_SHIFT   (TILE_SHIFT),
    .RW           (RW),
    .CW           (CW)
  ) u_pattern (
    .i_row      (r_row),
    .i_col      (r_col),
    .i_frame_odd(r_frame[0]),
    .o_word     (w_pattern)
  );

  assign w_word_addr = 16'(BASE_ADDR) + 16'(r_row) * 16'(WORDS_PER_ROW) + 16'(r_col);
  assign w_last_col  = (r_col == CW'(WORDS_PER_ROW - 1));
  assign w_last_row  = (r_row == RW'(ROWS - 1));

  always_comb begin
    w_state_n   = r_state;
    w_row_n     = r_row;
    w_col_n     = r_col;
    w_frame_n   = r_frame;
    w_gap_n     = r_gap;
    w_address_n = 16'(BASE_ADDR);
    w_load_n    = 1'b0;
    w_out_n     = 16'h0000;
    case (r_state)
      PAINT: begin
        w_load_n    = 1'b1;
        w_address_n = w_word_addr;
        w_out_n     = w_pattern;
        if (w_last_col) begin
          w_col_n = '0;
          if (w_last_row) begin
            w_row_n   = '0;
            w_state_n = GAP;
            w_frame_n = r_frame + 8'd1;
            w_gap_n   = '0;
          end else begin
            w_row_n = r_row + RW'(1);
          end
        end else begin
          w_col_n = r_col + CW'(1);
        end
      end
      GAP: begin
        if (r_gap == GW'(GAP_CYCLES - 1)) begin
          w_state_n = PAINT;
        end else begin
          w_gap_n = r_gap + GW'(1);
        end
      end
      default: w_state_n = PAINT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= PAINT;
      r_row     <= '0;
      r_col     <= '0;
      r_frame   <= 8'd0;
      r_gap     <= '0;
      r_address <= 16'(BASE_ADDR);
      r_load    <= 1'b0;
      r_out     <= 16'h0000;
    end else begin
      r_state   <= w_state_n;
      r_row     <= w_row_n;
      r_col     <= w_col_n;
      r_frame   <= w_frame_n;
      r_gap     <= w_gap_n;
      r_address <= w_address_n;
      r_load    <= w_load_n;
      r_out     <= w_out_n;
    end
  end

  assign address     = r_address;
  assign load        = r_load;
  assign out         = r_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_image_generator.sv
// Bench for image_generator: pixel-level screen model, per-cycle scoreboard,
// literal pins on key writes, and randomized reset timing.
module tb_image_generator;
  import image_gen_pkg::*;

  localparam int BASE        = 16384;
  localparam int FRAME_WORDS = 8192;
  localparam int FRAME_LEN   = 8196;
  localparam int SCREEN_W    = 512;
  localparam int SCREEN_H    = 256;

  // clock / reset
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address;
  logic        load;
  logic [15:0] out;
  state_t      dbg_state;

  always #5 clk = ~clk;

  image_generator dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .load       (load),
    .out        (out),
    .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit pin_en = 1'b0;

  logic [32:0] exp_q[$];
  int          idx_q[$];
  logic [32:0] pin_exp[int];
  logic [32:0] reset_val;

  // Screen model: n-th output cycle since reset release -> {address, load, out}.
  function automatic logic [32:0] model(int n);
    int pos;
    int f;
    int y;
    int x;
    int c;
    bit on;
    logic [15:0] w;
    pos = n % FRAME_LEN;
    f   = n / FRAME_LEN;
    if (pos >= FRAME_WORDS) return {16'(BASE), 1'b0, 16'h0000};
    y = pos / 32;
    c = pos % 32;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      x  = c * 16 + i;
      on = (y == 0) || (y == SCREEN_H - 1) || (x == 0) || (x == SCREEN_W - 1) ||
           ((((y / 16) + (x / 16) + f) % 2) == 1);
      w[i] = on;
    end
    return {16'(BASE + pos), 1'b1, w};
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got addr=%0d load=%b out=%h want addr=%0d load=%b out=%h",
               name, act[32:17], act[16], act[15:0], exp[32:17], exp[16], exp[15:0]);
    end
  endtask

  // scoreboard producer
  always @(posedge clk) begin
    if (reset) begin
      cyc = 0;
      exp_q.delete();
      idx_q.delete();
    end else begin
      exp_q.push_back(model(cyc));
      idx_q.push_back(cyc);
      cyc++;
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [32:0] e;
    int          i;
    if (reset) begin
      check("reset_hold", {address, load, out}, reset_val);
      check("reset_state", {32'd0, dbg_state}, {32'd0, PAINT});
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      i = idx_q.pop_front();
      check($sformatf("cycle_%0d", i), {address, load, out}, e);
      if (pin_en && pin_exp.exists(i))
        check($sformatf("pin_%0d", i), {address, load, out}, pin_exp[i]);
    end
  end

  task automatic async_reset_check(input string name);
    #2 reset = 1'b1;
    #1 check(name, {address, load, out}, reset_val);
  endtask

  initial begin
    reset_val = {16'(BASE), 1'b0, 16'h0000};

    pin_exp[0]             = {16'd16384, 1'b1, 16'hFFFF};
    pin_exp[31]            = {16'd16415, 1'b1, 16'hFFFF};
    pin_exp[32]            = {16'd16416, 1'b1, 16'h0001};
    pin_exp[33]            = {16'd16417, 1'b1, 16'hFFFF};
    pin_exp[34]            = {16'd16418, 1'b1, 16'h0000};
    pin_exp[63]            = {16'd16447, 1'b1, 16'hFFFF};
    pin_exp[512]           = {16'd16896, 1'b1, 16'hFFFF};
    pin_exp[513]           = {16'd16897, 1'b1, 16'h0000};
    pin_exp[8191]          = {16'd24575, 1'b1, 16'hFFFF};
    pin_exp[8192]          = {16'd16384, 1'b0, 16'h0000};
    pin_exp[8195]          = {16'd16384, 1'b0, 16'h0000};
    pin_exp[8196]          = {16'd16384, 1'b1, 16'hFFFF};
    pin_exp[8196 + 32]     = {16'd16416, 1'b1, 16'hFFFF};
    pin_exp[8196 + 33]     = {16'd16417, 1'b1, 16'h0000};

    foreach (pin_exp[k]) check($sformatf("model_pin_%0d", k), model(k), pin_exp[k]);

    // reset hold, short run, then async reset mid-cycle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat ($urandom_range(5, 40)) @(posedge clk);
    async_reset_check("async_reset_early");
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 reset = 1'b0;
    pin_en = 1'b1;

    // frame 0, gap, then reset partway into frame 1
    repeat (FRAME_LEN + 5000) @(posedge clk);
    pin_en = 1'b0;
    async_reset_check("async_reset_frame1");
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 reset = 1'b0;
    pin_en = 1'b1;

    // restart from frame 0, through two gaps into frame 2
    repeat (2 * FRAME_LEN + 100) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
